m_block_unpadder: RTL and testbench

//  Receive end of the SHA-256 padding stage: accepts padded 512-bit blocks as
//  16 big-endian 32-bit words, recovers the original byte stream using the
//  64-bit length field, and re-emits the message bytes one per handshake.

---
 rtl/sha_pkg.sv | 22 ++
 rtl/m_block_unpadder_if.sv | 30 +++
 rtl/m_block_bank.sv | 54 +++++
 rtl/m_block_unpadder.sv | 199 +++++++++++++++++++
 tb/tb_m_block_unpadder.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/sha_pkg.sv
// Shared constants and FSM encoding for the SHA-256 block unpadder.
package sha_pkg;

  localparam int unsigned BLOCK_BYTES     = 64;
  localparam int unsigned WORDS_PER_BLOCK = 16;
  localparam int unsigned LEN_OFS         = 56;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned LEN_W           = 64;
  localparam int unsigned OFS_W           = $clog2(BLOCK_BYTES);
  localparam int unsigned IDX_W           = $clog2(WORDS_PER_BLOCK);

  localparam logic [BYTE_W-1:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    EMIT  = 2'd1,
    CHECK = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/m_block_unpadder_if.sv
// Word-in / byte-out handshake bundle of the block unpadder.
interface m_block_unpadder_if #(
  parameter int unsigned CNT_W = 64
) ();
  import sha_pkg::*;

  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic              block_last;
  logic [BYTE_W-1:0] data_out;
  logic              byte_rdy;
  logic              byte_ack;
  logic              byte_stop;
  logic              pad_err;
  logic [CNT_W-1:0]  byte_cnt;

  // Source of words and consumer of bytes
  modport master (
    output word_in, word_valid, block_last, byte_ack,
    input  word_ready, data_out, byte_rdy, byte_stop, pad_err, byte_cnt
  );

  // The unpadder itself
  modport slave (
    input  word_in, word_valid, block_last, byte_ack,
    output word_ready, data_out, byte_rdy, byte_stop, pad_err, byte_cnt
  );

endinterface

// File: rtl/m_block_bank.sv
// Ping-pong storage: two 64-byte banks, word write port, byte read port,
// per-bank full/last flags.
module m_block_bank
  import sha_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_word,
  input  logic              wr_last,
  input  logic              free_en,
  input  logic              free_bank,
  input  logic              rd_bank,
  input  logic [OFS_W-1:0]  rd_ofs,
  output logic [BYTE_W-1:0] rd_byte_c,
  output logic [1:0]        full,
  output logic [1:0]        last
);

  logic [BYTE_W-1:0] mem [2][BLOCK_BYTES];

  // Big-endian word split: [31:24] lands at the lowest byte address
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][{wr_idx, 2'd0}] <= wr_word[31:24];
      mem[wr_bank][{wr_idx, 2'd1}] <= wr_word[23:16];
      mem[wr_bank][{wr_idx, 2'd2}] <= wr_word[15:8];
      mem[wr_bank][{wr_idx, 2'd3}] <= wr_word[7:0];
    end
  end

  // Bank becomes full on its last word; freed by the reader or by a message clear
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      full <= 2'b00;
      last <= 2'b00;
    end else begin
      if (free_en) begin
        full[free_bank] <= 1'b0;
        last[free_bank] <= 1'b0;
      end
      if (wr_en && (wr_idx == IDX_W'(WORDS_PER_BLOCK - 1))) begin
        full[wr_bank] <= 1'b1;
        last[wr_bank] <= wr_last;
      end
    end
  end

  assign rd_byte_c = mem[rd_bank][rd_ofs];

endmodule

// File: rtl/m_block_unpadder.sv
// Receive end of SHA-256 padding: buffers padded blocks, recovers the message
// bytes from the length field and flags malformed padding.
module m_block_unpadder
  import sha_pkg::*;
#(
  parameter int unsigned CNT_W = 64
) (
  input logic               clk,
  input logic               rst,
  m_block_unpadder_if.slave bus
);

  state_t            state_q, state_nx;
  logic              wr_bank_q;
  logic [IDX_W-1:0]  wr_idx_q;
  logic              rd_bank_q, rd_bank_nx;
  logic [WORD_W-1:0] len_hi_q;
  logic [LEN_W-1:0]  len_q;
  logic              len_known_q;
  logic [CNT_W-1:0]  blk_cnt_q;

  logic [BYTE_W-1:0] data_out_q, data_out_nx;
  logic              byte_rdy_q, byte_rdy_nx;
  logic              byte_stop_q, byte_stop_nx;
  logic              pad_err_q, pad_err_nx;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_nx;

  logic              free_en_c;
  logic              clr_c;
  logic              word_ready_c;
  logic              word_accept_c;
  logic              emit_ok_c;
  logic              consistent_c;
  logic [OFS_W-1:0]  rd_ofs_c;
  logic [BYTE_W-1:0] rd_byte_c;
  logic [1:0]        full;
  logic [1:0]        last;
  logic [CNT_W-1:0]  n_len_c;
  logic [CNT_W-1:0]  n_p9_c;
  logic [CNT_W-1:0]  t_len_c;

  // Once the final block is in, further words belong to the next message and
  // would be wiped by the end-of-message clear, so hold them off.
  assign word_ready_c  = !rst && !full[wr_bank_q] && !len_known_q && (state_q != STOP);
  assign word_accept_c = bus.word_valid && word_ready_c;

  // Byte offset inside the read bank tracks the message byte counter
  assign rd_ofs_c = byte_cnt_q[OFS_W-1:0];

  m_block_bank u_bank (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_c),
    .wr_en     (word_accept_c),
    .wr_bank   (wr_bank_q),
    .wr_idx    (wr_idx_q),
    .wr_word   (bus.word_in),
    .wr_last   (bus.block_last),
    .free_en   (free_en_c),
    .free_bank (rd_bank_q),
    .rd_bank   (rd_bank_q),
    .rd_ofs    (rd_ofs_c),
    .rd_byte_c (rd_byte_c),
    .full      (full),
    .last      (last)
  );

  // Write side: word index, bank pointer, block count and length capture
  always_ff @(posedge clk) begin
    if (rst || clr_c) begin
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      len_hi_q    <= '0;
      len_q       <= '0;
      len_known_q <= 1'b0;
      blk_cnt_q   <= '0;
    end else if (word_accept_c) begin
      wr_idx_q <= wr_idx_q + IDX_W'(1);
      if (wr_idx_q == IDX_W'(LEN_OFS / 4)) begin
        len_hi_q <= bus.word_in;
      end
      if (wr_idx_q == IDX_W'(WORDS_PER_BLOCK - 1)) begin
        wr_bank_q <= !wr_bank_q;
        blk_cnt_q <= blk_cnt_q + CNT_W'(1);
        if (bus.block_last) begin
          len_known_q <= 1'b1;
          len_q       <= {len_hi_q, bus.word_in};
        end
      end
    end
  end

  // Length check: bit length a whole number of bytes and N+9 fits the last block
  always_comb begin
    n_len_c      = CNT_W'(len_q >> 3);
    n_p9_c       = n_len_c + CNT_W'(9);
    t_len_c      = {blk_cnt_q[CNT_W-OFS_W-1:0], OFS_W'(0)};
    consistent_c = (len_q[2:0] == 3'b000) &&
                   ((t_len_c - CNT_W'(BLOCK_BYTES)) < n_p9_c) &&
                   (n_p9_c <= t_len_c);
  end

  // Read bank released only when the length is guaranteed known before its pad byte
  assign emit_ok_c = full[rd_bank_q] && (full[!rd_bank_q] || last[rd_bank_q]);

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      rd_bank_q   <= 1'b0;
      data_out_q  <= '0;
      byte_rdy_q  <= 1'b0;
      byte_stop_q <= 1'b0;
      pad_err_q   <= 1'b0;
      byte_cnt_q  <= '0;
    end else begin
      state_q     <= state_nx;
      rd_bank_q   <= rd_bank_nx;
      data_out_q  <= data_out_nx;
      byte_rdy_q  <= byte_rdy_nx;
      byte_stop_q <= byte_stop_nx;
      pad_err_q   <= pad_err_nx;
      byte_cnt_q  <= byte_cnt_nx;
    end
  end

  // Next state and output values
  always_comb begin
    state_nx     = state_q;
    rd_bank_nx   = rd_bank_q;
    data_out_nx  = data_out_q;
    byte_rdy_nx  = byte_rdy_q;
    byte_stop_nx = 1'b0;
    pad_err_nx   = 1'b0;
    byte_cnt_nx  = byte_cnt_q;
    free_en_c    = 1'b0;
    clr_c        = 1'b0;

    case (state_q)
      FILL: begin
        if (emit_ok_c) begin
          state_nx = EMIT;
        end
      end

      EMIT: begin
        if (byte_rdy_q) begin
          if (bus.byte_ack) begin
            byte_rdy_nx = 1'b0;
            byte_cnt_nx = byte_cnt_q + CNT_W'(1);
            if (rd_ofs_c == OFS_W'(BLOCK_BYTES - 1)) begin
              if (last[rd_bank_q]) begin
                // Buffered data ran out before N was reached: length overshoots
                state_nx     = CHECK;
                byte_stop_nx = 1'b1;
                pad_err_nx   = 1'b1;
              end else begin
                free_en_c  = 1'b1;
                rd_bank_nx = !rd_bank_q;
                state_nx   = FILL;
              end
            end
          end
        end else if (len_known_q && (byte_cnt_q == n_len_c)) begin
          // Read offset already equals N%64, so the pad byte is on the read port
          state_nx     = CHECK;
          byte_stop_nx = 1'b1;
          pad_err_nx   = !consistent_c || (rd_byte_c != PAD_BYTE);
        end else begin
          byte_rdy_nx = 1'b1;
          data_out_nx = rd_byte_c;
        end
      end

      CHECK: begin
        state_nx = STOP;
      end

      STOP: begin
        clr_c       = 1'b1;
        rd_bank_nx  = 1'b0;
        byte_cnt_nx = '0;
        state_nx    = FILL;
      end

      default: begin
        state_nx = FILL;
      end
    endcase
  end

  assign bus.word_ready = word_ready_c;
  assign bus.data_out   = data_out_q;
  assign bus.byte_rdy   = byte_rdy_q;
  assign bus.byte_stop  = byte_stop_q;
  assign bus.pad_err    = pad_err_q;
  assign bus.byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_m_block_unpadder.sv
// Directed bench for m_block_unpadder: pads messages locally, streams the
// blocks in and checks the recovered bytes, timing and error flag.
`timescale 1ns/1ps
module tb_m_block_unpadder;
  import sha_pkg::*;

  localparam int unsigned CNT_W = 64;
  localparam int NO_STOP = 1 << 30;

  logic clk = 1'b0;
  logic rst;

  m_block_unpadder_if #(.CNT_W(CNT_W)) bus ();

  m_block_unpadder #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] msg_q [$];
  logic [7:0] pbuf [128];
  int         nblk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Standard SHA-256 padding of msg_q into pbuf
  task automatic build_msg();
    int n;
    logic [63:0] bits;
    n    = msg_q.size();
    bits = 64'(n) << 3;
    nblk = (n + 9 + 63) / 64;
    for (int i = 0; i < 128; i++) pbuf[i] = 8'h00;
    for (int i = 0; i < n; i++) pbuf[i] = msg_q[i];
    pbuf[n] = 8'h80;
    for (int i = 0; i < 8; i++) pbuf[nblk*64 - 8 + i] = bits[63 - 8*i -: 8];
  endtask

  task automatic send_msg();
    int budget;
    for (int b = 0; b < nblk; b++) begin
      for (int w = 0; w < 16; w++) begin
        bus.word_in    = {pbuf[b*64 + 4*w], pbuf[b*64 + 4*w + 1],
                          pbuf[b*64 + 4*w + 2], pbuf[b*64 + 4*w + 3]};
        bus.block_last = (b == nblk - 1);
        bus.word_valid = 1'b1;
        budget = 200;
        while (!bus.word_ready && budget > 0) begin
          tick();
          budget--;
        end
        if (budget == 0) check("word_ready_wait", 64'(bus.word_ready), 64'd1);
        tick();
        bus.word_valid = 1'b0;
        bus.block_last = 1'b0;
        check("no_early_rdy", 64'(bus.byte_rdy), 64'd0);
      end
    end
  endtask

  // Consume bytes until byte_stop (or until byte index stop_at is presented)
  task automatic recv(input bit exp_err, input int hold_at, input int stop_at);
    int got;
    int budget;
    bit done;
    got = 0; budget = 3000; done = 1'b0;
    while (!done) begin
      if (bus.byte_stop) begin
        check("byte_count", 64'(got), 64'(msg_q.size()));
        check("pad_err", 64'(bus.pad_err), 64'(exp_err));
        check("byte_cnt_at_stop", bus.byte_cnt, 64'(msg_q.size()));
        tick();
        check("stop_pulse", 64'(bus.byte_stop), 64'd0);
        done = 1'b1;
      end else if (bus.byte_rdy) begin
        if (got >= stop_at) begin
          done = 1'b1;
        end else begin
          if (got < msg_q.size()) check($sformatf("data[%0d]", got), 64'(bus.data_out), 64'(msg_q[got]));
          else check("extra_byte", 64'(got), 64'(msg_q.size()));
          check($sformatf("cnt[%0d]", got), bus.byte_cnt, 64'(got));
          if (got == hold_at) begin
            for (int k = 0; k < 10; k++) begin
              tick();
              check("hold_rdy", 64'(bus.byte_rdy), 64'd1);
              check("hold_data", 64'(bus.data_out), 64'(msg_q[got]));
            end
          end
          bus.byte_ack = 1'b1;
          tick();
          bus.byte_ack = 1'b0;
          got++;
        end
      end else if (budget == 0) begin
        check("byte_wait", 64'(bus.byte_rdy | bus.byte_stop), 64'd1);
        done = 1'b1;
      end else begin
        budget--;
        tick();
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data_out"},  64'(bus.data_out),  64'd0);
    check({tag, "_byte_rdy"},  64'(bus.byte_rdy),  64'd0);
    check({tag, "_byte_stop"}, 64'(bus.byte_stop), 64'd0);
    check({tag, "_pad_err"},   64'(bus.pad_err),   64'd0);
    check({tag, "_byte_cnt"},  bus.byte_cnt,       64'd0);
  endtask

  task automatic load_abc();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
    build_msg();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.word_in    = '0;
    bus.word_valid = 1'b0;
    bus.block_last = 1'b0;
    bus.byte_ack   = 1'b0;
    repeat (3) tick();
    check("rst_word_ready", 64'(bus.word_ready), 64'd0);
    check_idle_outputs("rst");
    rst = 1'b0;
    tick();
    check("post_rst_word_ready", 64'(bus.word_ready), 64'd1);

    // 1: "abc", first byte 2 cycles after last accepted word
    load_abc();
    send_msg();
    check("abc_rdy_t0", 64'(bus.byte_rdy), 64'd0);
    tick();
    check("abc_rdy_t1", 64'(bus.byte_rdy), 64'd0);
    tick();
    check("abc_rdy_t2", 64'(bus.byte_rdy), 64'd1);
    recv(1'b0, -1, NO_STOP);

    // 2: 56-byte message, pad byte in the penultimate block
    msg_q.delete();
    for (int i = 0; i < 56; i++) msg_q.push_back(8'h41);
    build_msg();
    send_msg();
    recv(1'b0, -1, NO_STOP);

    // 3: empty message, byte_stop 2 cycles after the last word
    msg_q.delete();
    build_msg();
    send_msg();
    tick();
    check("empty_stop_t1", 64'(bus.byte_stop), 64'd0);
    tick();
    check("empty_stop_t2", 64'(bus.byte_stop), 64'd1);
    recv(1'b0, -1, NO_STOP);

    // 4: 64-byte message, consumer stalls 10 cycles at byte 5
    msg_q.delete();
    for (int i = 0; i < 64; i++) msg_q.push_back(8'(i * 3 + 1));
    build_msg();
    send_msg();
    recv(1'b0, 5, NO_STOP);

    // 5a: pad byte corrupted
    load_abc();
    pbuf[3] = 8'h00;
    send_msg();
    recv(1'b1, -1, NO_STOP);

    // 5b: bit length not a multiple of 8
    load_abc();
    pbuf[63] = 8'h19;
    send_msg();
    recv(1'b1, -1, NO_STOP);

    // 6: reset while byte 20 of a 2-block message is presented
    msg_q.delete();
    for (int i = 0; i < 100; i++) msg_q.push_back(8'(i + 8'h10));
    build_msg();
    send_msg();
    recv(1'b0, -1, 20);
    check("pre_rst_rdy", 64'(bus.byte_rdy), 64'd1);
    check("pre_rst_cnt", bus.byte_cnt, 64'd20);
    rst = 1'b1;
    #1;
    check("mid_rst_word_ready", 64'(bus.word_ready), 64'd0);
    tick();
    rst = 1'b0;
    check_idle_outputs("mid_rst");
    #1;
    check("after_rst_word_ready", 64'(bus.word_ready), 64'd1);
    load_abc();
    send_msg();
    recv(1'b0, -1, NO_STOP);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
